// File: rtl/apb_arbiter_master_pkg.sv
// Shared definitions for the two-requester APB master: FSM encoding and default timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_arbiter_master_pkg;

  // Transfer sequencing states of the APB master
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RDWAIT = 2'd3
  } apb_state_t;

  // ACCESS cycles without Pready before the transfer is abandoned
  localparam int DEFAULT_TIMEOUT = 15;

  // Width of the ACCESS-cycle wait counter
  localparam int TO_CNT_W = 4;

endpackage

// File: rtl/apb_arbiter_master_rr_arb2.sv
// Two-way round-robin arbiter: a contested request goes to the side not granted last.
// Latency: combinational grant; the priority pointer moves on the clock after an accepted grant.
// Backpressure: grant is only taken when 'advance' is high; otherwise the pointer holds.
module rr_arb2 (
  input  logic       Pclk,
  input  logic       Preset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last = index of the most recently granted requester
  logic last;

  // Pick a single winner; only a contested request consults the pointer
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Pointer starts as "requester 1 went last" so requester 0 wins first after reset
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      last <= 1'b1;
    end else if (advance && (|req)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/apb_arbiter_master.sv
// Arbitrates two requesters onto one APB master port addressing two slaves (addr MSB selects).
// Latency: grant in IDLE, SETUP+ACCESS(>=1)[+RDWAIT], done pulse the cycle after completion.
// Backpressure: one transfer in flight; new grants only in IDLE; stalled slaves time out.
module apb_arbiter_master
  import apb_arbiter_master_pkg::*;
#(
  parameter int ADD_WIDTH = 9,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int RDATA_LAT = 1
) (
  input  logic                     Pclk,
  input  logic                     Preset,
  input  logic [1:0]               Req_valid,
  input  logic [1:0]               Req_write,
  input  logic [2*ADD_WIDTH-1:0]   Req_addr,
  input  logic [2*WIDTH-1:0]       Req_wdata,
  input  logic [2*(WIDTH/8)-1:0]   Req_strb,
  output logic [1:0]               Req_gnt,
  output logic [1:0]               Req_done,
  output logic                     Req_err,
  output logic [WIDTH-1:0]         Req_rdata,
  output logic                     Psel1,
  output logic                     Psel2,
  output logic                     Penable,
  output logic                     Pwrite,
  output logic [ADD_WIDTH-2:0]     Paddr,
  output logic [WIDTH-1:0]         Pwdata,
  output logic [WIDTH/8-1:0]       Pstrb,
  input  logic [WIDTH-1:0]         Prdata1,
  input  logic [WIDTH-1:0]         Prdata2,
  input  logic                     Pready1,
  input  logic                     Pready2
);

  localparam int SW = WIDTH / 8;
  localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TIMEOUT);

  apb_state_t state, state_nxt;

  // Fields of the transfer in flight, frozen at grant time
  logic                 owner_q;
  logic [ADD_WIDTH-1:0] addr_q;
  logic                 write_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [SW-1:0]        strb_q;
  logic [TO_CNT_W-1:0]  to_cnt;

  logic [1:0]       arb_gnt;
  logic             advance;
  logic             sel2;
  logic             pready_sel;
  logic [WIDTH-1:0] prdata_sel;
  logic             to_hit;
  logic [1:0]       owner_oh;

  rr_arb2 u_arb (
    .Pclk    (Pclk),
    .Preset  (Preset),
    .req     (Req_valid),
    .advance (advance),
    .gnt     (arb_gnt)
  );

  // Only the addressed slave's handshake and read data are ever looked at
  assign sel2       = addr_q[ADD_WIDTH-1];
  assign pready_sel = sel2 ? Pready2 : Pready1;
  assign prdata_sel = sel2 ? Prdata2 : Prdata1;
  assign to_hit     = (to_cnt + 1'b1) == TO_LIM;
  assign owner_oh   = owner_q ? 2'b10 : 2'b01;

  assign Paddr  = addr_q[ADD_WIDTH-2:0];
  assign Pwrite = write_q;
  assign Pwdata = wdata_q;
  assign Pstrb  = strb_q;

  // State register
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and APB/grant outputs; selects are low outside SETUP/ACCESS
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    Req_gnt   = 2'b00;
    Psel1     = 1'b0;
    Psel2     = 1'b0;
    Penable   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((|Req_valid) && !Preset) begin
          advance   = 1'b1;
          Req_gnt   = arb_gnt;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        Psel1     = !sel2;
        Psel2     = sel2;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        Psel1   = !sel2;
        Psel2   = sel2;
        Penable = 1'b1;
        if (pready_sel) begin
          state_nxt = (write_q || (RDATA_LAT == 0)) ? ST_IDLE : ST_RDWAIT;
        end else if (to_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latch, wait counter and one-cycle completion report
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      owner_q   <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      to_cnt    <= '0;
      Req_done  <= 2'b00;
      Req_err   <= 1'b0;
      Req_rdata <= '0;
    end else begin
      Req_done  <= 2'b00;
      Req_err   <= 1'b0;
      Req_rdata <= '0;
      if (advance) begin
        owner_q <= arb_gnt[1];
        addr_q  <= arb_gnt[1] ? Req_addr[2*ADD_WIDTH-1:ADD_WIDTH] : Req_addr[ADD_WIDTH-1:0];
        write_q <= arb_gnt[1] ? Req_write[1] : Req_write[0];
        wdata_q <= arb_gnt[1] ? Req_wdata[2*WIDTH-1:WIDTH] : Req_wdata[WIDTH-1:0];
        strb_q  <= arb_gnt[1] ? Req_strb[2*SW-1:SW] : Req_strb[SW-1:0];
      end
      if (state == ST_SETUP) begin
        to_cnt <= '0;
      end
      if (state == ST_ACCESS) begin
        if (pready_sel) begin
          if (write_q) begin
            Req_done <= owner_oh;
          end else if (RDATA_LAT == 0) begin
            Req_done  <= owner_oh;
            Req_rdata <= prdata_sel;
          end
        end else if (to_hit) begin
          Req_done <= owner_oh;
          Req_err  <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (state == ST_RDWAIT) begin
        Req_done  <= owner_oh;
        Req_rdata <= prdata_sel;
      end
    end
  end

endmodule

// File: doc/apb_arbiter_master.md
APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 Parameters: ADD_WIDTH, default 9, requester address width; bit ADD_WIDTH-1 selects the slave.
REQ-002 Parameters: WIDTH, default 32, data width; strobe width WIDTH/8.
REQ-003 Parameters: TIMEOUT, default 15, maximum ACCESS cycles without Pready.
REQ-004 Parameters: RDATA_LAT, default 1, cycles from Pready to valid slave Prdata; legal values 0 and 1.
REQ-005 Port Pclk  in  1  single clock; all state updates on its rising edge.
REQ-006 Port Preset  in  1  synchronous reset, active-high.
REQ-007 Port Req_valid  in  2  per-requester request; bit i belongs to requester i.
REQ-008 Port Req_write  in  2  per-requester direction; 1 = write.
REQ-009 Port Req_addr  in  2*ADD_WIDTH  packed; requester i uses slice [i*ADD_WIDTH +: ADD_WIDTH].
REQ-010 Port Req_wdata  in  2*WIDTH  packed write data.
REQ-011 Port Req_strb  in  2*WIDTH/8  packed byte strobes.
REQ-012 Port Req_gnt  out  2  one-cycle pulse; the request is accepted and its fields are latched.
REQ-013 Port Req_done  out  2  one-cycle completion pulse.
REQ-014 Port Req_err  out  1  timeout flag; valid only while a Req_done bit is high.
REQ-015 Port Req_rdata  out  WIDTH  read data; valid only while a Req_done bit is high.
REQ-016 Port Psel1, Psel2  out  1 each  slave selects.
REQ-017 Port Penable, Pwrite  out  1 each  APB controls.
REQ-018 Port Paddr  out  ADD_WIDTH-1  slave-local address.
REQ-019 Port Pwdata  out  WIDTH; Pstrb  out  WIDTH/8.
REQ-020 Port Prdata1, Prdata2  in  WIDTH; Pready1, Pready2  in  1.

Function
REQ-021 The FSM SHALL have the states IDLE, SETUP, ACCESS and RDWAIT.
REQ-022 IDLE: if any Req_valid bit is high, the block SHALL grant one requester, pulse its Req_gnt, latch addr/write/wdata/strb, and go to SETUP next cycle.
REQ-023 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; after reset, requester 0 wins.
REQ-024 SETUP: assert Psel1 if latched addr MSB = 0, else Psel2; Penable = 0; drive Paddr = addr[ADD_WIDTH-2:0], Pwrite, Pwdata, Pstrb; next state ACCESS.
REQ-025 ACCESS: Penable = 1 and the same Psel held; Pready is taken from the selected slave only.
REQ-026 ACCESS with Pready and (write or RDATA_LAT = 0): capture rdata (reads only), pulse Req_done next cycle, go to IDLE.
REQ-027 ACCESS with Pready and read and RDATA_LAT = 1: go to RDWAIT with Psel and Penable low.
REQ-028 RDWAIT: capture the selected Prdata, pulse Req_done next cycle, go to IDLE.
REQ-029 Timeout: a 4-bit counter SHALL count ACCESS cycles with Pready low; when it reaches TIMEOUT, drop Psel/Penable, return to IDLE, and pulse Req_done with Req_err = 1 and Req_rdata = 0.
REQ-030 Psel and Penable SHALL be low in IDLE and RDWAIT, and for at least one IDLE cycle between transfers (no back-to-back SETUP).
REQ-031 Req_valid changes after Req_gnt SHALL NOT affect the transfer in flight.
REQ-032 Req_err SHALL be 0 on successful completions; Req_rdata SHALL be 0 on writes.

Reset
REQ-033 Preset SHALL force IDLE, zero all outputs and counters, and set the round-robin pointer to favour requester 0.
REQ-034 Reset mid-transfer SHALL drop Psel/Penable next cycle with no Req_done pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the default TIMEOUT constant.
REQ-036 The round-robin arbiter SHALL be a sub-module, rr_arb2 (req[1:0], advance -> gnt[1:0]).

Verification
REQ-037 Single write: requester 0 writes addr 0x005, data 0xA5A5A5A5, strb 0xF to a slave with Pready on the 4th ACCESS cycle -> Psel1 for 5 cycles, Req_done[0] pulses, Req_err = 0.
REQ-038 Read-back: requester 1 reads addr 0x005 with RDATA_LAT = 1 -> RDWAIT entered, Req_rdata = 0xA5A5A5A5, Req_done[1] pulses.
REQ-039 Contention: both requesters valid continuously -> grants alternate 0,1,0,1; Psel1 for addr 0x010 and Psel2 for addr 0x110.
REQ-040 Timeout: Pready held low -> Req_done pulses with Req_err = 1 and Req_rdata = 0 after 15 ACCESS cycles; Psel drops.
REQ-041 Partial strobe: write 0x11223344 with strb 0x3, then read -> upper bytes keep their old value.
REQ-042 Reset asserted during ACCESS -> Psel/Penable low next cycle, no Req_done, the next grant goes to requester 0.
